obstacle_generator: RTL and testbench

Produces the obstacle box the collision detector checks against the player. It spawns one obstacle at a time at the right screen edge, with pseudo-random height and spawn gap, and moves it left by a fixed step each frame. It despawns the obstacle at the left edge and counts it as cleared. On a collision it freezes play, raises game_over and waits for a restart. Sits between the frame-timing logic (frame_tick) and the collision detector and renderer.

---
 rtl/obstacle_generator_pkg.sv | 19 +
 rtl/obstacle_generator_lfsr8.sv | 25 ++
 rtl/obstacle_generator.sv | 152 +++++++++++++++
 tb/tb_obstacle_generator.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_generator_pkg.sv
// Shared game constants and obstacle FSM encoding.
// Imported by the obstacle generator and the collision detector.
package obstacle_generator_pkg;

    localparam logic [9:0] SCREEN_WIDTH  = 10'd640;
    localparam logic [9:0] GROUND_Y      = 10'd345;

    localparam logic [9:0] PLAYER_Y      = 10'd315;
    localparam logic [9:0] PLAYER_WIDTH  = 10'd20;
    localparam logic [9:0] PLAYER_HEIGHT = 10'd30;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPAWN = 2'd1,
        MOVING     = 2'd2,
        FROZEN     = 2'd3
    } obs_state_t;

endpackage

// File: rtl/obstacle_generator_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Steps once per advance pulse; a non-zero seed never reaches 0.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [7:0] value
);

    logic fb;

    assign fb = value[7] ^ value[5] ^ value[4] ^ value[3];

    // Shift in the feedback bit at the bottom on each advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (advance) begin
            value <= {value[6:0], fb};
        end
    end

endmodule

// File: rtl/obstacle_generator.sv
// Spawns, moves and despawns a single obstacle.
// Freezes on collision until start restarts play.
module obstacle_generator
    import obstacle_generator_pkg::*;
#(
    parameter logic [9:0] OBS_WIDTH  = 10'd20,
    parameter logic [9:0] MIN_HEIGHT = 10'd20,
    parameter logic [9:0] SPEED      = 10'd4,
    parameter logic [7:0] GAP_BASE   = 8'd30,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collision,
    output logic [9:0]  obstacle_x,
    output logic [9:0]  obstacle_y,
    output logic [9:0]  obstacle_width,
    output logic [9:0]  obstacle_height,
    output logic        obstacle_active,
    output logic        game_over,
    output logic [15:0] score
);

    obs_state_t  state, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  y_q;
    logic        act_q, act_d;
    logic        go_q, go_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  gap_load;
    logic [9:0]  spawn_h;
    logic [7:0]  lfsr_v;

    lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(frame_tick),
        .value  (lfsr_v)
    );

    // Random draws use the LFSR value before this tick advances it.
    assign gap_load = GAP_BASE + {4'd0, lfsr_v[3:0]};
    assign spawn_h  = MIN_HEIGHT + {4'd0, lfsr_v[5:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next obstacle/game values; collision outranks a tick.
    always_comb begin
        state_d = state;
        x_d     = x_q;
        h_d     = h_q;
        act_d   = act_q;
        go_d    = go_q;
        score_d = score_q;
        gap_d   = gap_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    gap_d   = gap_load;
                    state_d = WAIT_SPAWN;
                end
            end
            WAIT_SPAWN: begin
                if (frame_tick) begin
                    if (gap_q == 8'd1) begin
                        gap_d   = 8'd0;
                        h_d     = spawn_h;
                        x_d     = SCREEN_WIDTH;
                        act_d   = 1'b1;
                        state_d = MOVING;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
            end
            MOVING: begin
                if (collision) begin
                    go_d    = 1'b1;
                    state_d = FROZEN;
                end else if (frame_tick) begin
                    if (x_q >= SPEED) begin
                        x_d = x_q - SPEED;
                    end else begin
                        act_d   = 1'b0;
                        h_d     = 10'd0;
                        x_d     = SCREEN_WIDTH;
                        gap_d   = gap_load;
                        state_d = WAIT_SPAWN;
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                    end
                end
            end
            FROZEN: begin
                if (start) begin
                    go_d    = 1'b0;
                    score_d = 16'd0;
                    act_d   = 1'b0;
                    h_d     = 10'd0;
                    x_d     = SCREEN_WIDTH;
                    gap_d   = gap_load;
                    state_d = WAIT_SPAWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Obstacle and game registers; y tracks the registered height.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= SCREEN_WIDTH;
            h_q     <= 10'd0;
            y_q     <= GROUND_Y;
            act_q   <= 1'b0;
            go_q    <= 1'b0;
            score_q <= 16'd0;
            gap_q   <= 8'd0;
        end else begin
            x_q     <= x_d;
            h_q     <= h_d;
            y_q     <= GROUND_Y - h_d;
            act_q   <= act_d;
            go_q    <= go_d;
            score_q <= score_d;
            gap_q   <= gap_d;
        end
    end

    assign obstacle_x      = x_q;
    assign obstacle_y      = y_q;
    assign obstacle_width  = OBS_WIDTH;
    assign obstacle_height = h_q;
    assign obstacle_active = act_q;
    assign game_over       = go_q;
    assign score           = score_q;

endmodule

// File: tb/tb_obstacle_generator.sv
// Testbench for obstacle_generator: directed scenarios
// plus random play checked against a behavioural model.
module tb_obstacle_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        collision = 1'b0;
    logic [9:0]  obstacle_x;
    logic [9:0]  obstacle_y;
    logic [9:0]  obstacle_width;
    logic [9:0]  obstacle_height;
    logic        obstacle_active;
    logic        game_over;
    logic [15:0] score;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain integers where possible).
    int          m_mode;   // 0 idle, 1 waiting, 2 moving, 3 frozen
    int          m_x;
    int          m_h;
    bit          m_act;
    bit          m_go;
    int          m_score;
    int          m_gap;
    logic [7:0]  m_lfsr;

    obstacle_generator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .start          (start),
        .collision      (collision),
        .obstacle_x     (obstacle_x),
        .obstacle_y     (obstacle_y),
        .obstacle_width (obstacle_width),
        .obstacle_height(obstacle_height),
        .obstacle_active(obstacle_active),
        .game_over      (game_over),
        .score          (score)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic [7:0] t;
        t = v & 8'hB8;
        return {v[6:0], ^t};
    endfunction

    task automatic model_step();
        int lo4;
        int lo6;
        if (!rst_n) begin
            m_mode = 0; m_x = 640; m_h = 0; m_act = 0;
            m_go = 0; m_score = 0; m_gap = 0; m_lfsr = 8'hA5;
            return;
        end
        lo4 = int'(m_lfsr) % 16;
        lo6 = int'(m_lfsr) % 64;
        case (m_mode)
            0: if (start) begin
                m_gap = 30 + lo4; m_mode = 1;
            end
            1: if (frame_tick) begin
                if (m_gap == 1) begin
                    m_gap = 0; m_h = 20 + lo6; m_x = 640;
                    m_act = 1; m_mode = 2;
                end else begin
                    m_gap = m_gap - 1;
                end
            end
            2: if (collision) begin
                m_go = 1; m_mode = 3;
            end else if (frame_tick) begin
                if (m_x >= 4) m_x = m_x - 4;
                else begin
                    m_act = 0; m_h = 0; m_x = 640;
                    m_gap = 30 + lo4; m_mode = 1;
                    if (m_score < 65535) m_score = m_score + 1;
                end
            end
            default: if (start) begin
                m_go = 0; m_score = 0; m_act = 0; m_h = 0;
                m_x = 640; m_gap = 30 + lo4; m_mode = 1;
            end
        endcase
        if (frame_tick) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic cycle(input bit ft, input bit st, input bit col);
        frame_tick = ft; start = st; collision = col;
        @(posedge clk);
        model_step();
        #1;
        frame_tick = 0; start = 0; collision = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) cycle(0, 0, 0);
        rst_n = 1;
    endtask

    task automatic wait_spawn(input string tag);
        for (int i = 0; i < 200 && !obstacle_active; i++) tick(1);
        n_tests++;
        if (obstacle_active !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_spawn_timeout: active=%b want 1",
                     tag, obstacle_active);
        end
    endtask

    task automatic wait_despawn(input string tag);
        for (int i = 0; i < 200 && obstacle_active; i++) tick(1);
        n_tests++;
        if (obstacle_active !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_despawn_timeout: active=%b want 0",
                     tag, obstacle_active);
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        n_tests++;
        if ({obstacle_x, obstacle_y, obstacle_height, obstacle_width}
            !== {10'd640, 10'd345, 10'd0, 10'd20}) begin
            n_fail++;
            $display("FAIL reset_geom: x=%0d y=%0d h=%0d w=%0d want 640 345 0 20",
                     obstacle_x, obstacle_y, obstacle_height, obstacle_width);
        end
        n_tests++;
        if ({obstacle_active, game_over, score} !== {1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_flags: act=%b go=%b score=%0d want 0 0 0",
                     obstacle_active, game_over, score);
        end
        tick(60);
        n_tests++;
        if (obstacle_active !== 1'b0 || obstacle_x !== 10'd640) begin
            n_fail++;
            $display("FAIL idle_no_spawn: act=%b x=%0d want 0 640",
                     obstacle_active, obstacle_x);
        end
    endtask

    task automatic test_spawn();
        do_reset(1);
        cycle(0, 1, 0);
        tick(34);
        n_tests++;
        if (obstacle_active !== 1'b0) begin
            n_fail++;
            $display("FAIL spawn_early: act=%b want 0 after 34 ticks",
                     obstacle_active);
        end
        tick(1);
        n_tests++;
        if (obstacle_active !== 1'b1 || obstacle_x !== 10'd640) begin
            n_fail++;
            $display("FAIL spawn_35: act=%b x=%0d want 1 640",
                     obstacle_active, obstacle_x);
        end
        n_tests++;
        if (obstacle_height < 10'd20 || obstacle_height > 10'd83
            || obstacle_height !== 10'(m_h)) begin
            n_fail++;
            $display("FAIL spawn_height: h=%0d want %0d (20..83)",
                     obstacle_height, m_h);
        end
        n_tests++;
        if (obstacle_y + obstacle_height !== 10'd345) begin
            n_fail++;
            $display("FAIL spawn_y: y=%0d h=%0d want y+h=345",
                     obstacle_y, obstacle_height);
        end
    endtask

    task automatic test_move_despawn();
        tick(10);
        n_tests++;
        if (obstacle_x !== 10'd600) begin
            n_fail++;
            $display("FAIL move_10: x=%0d want 600", obstacle_x);
        end
        tick(150);
        n_tests++;
        if (obstacle_x !== 10'd0 || obstacle_active !== 1'b1) begin
            n_fail++;
            $display("FAIL move_160: x=%0d act=%b want 0 1",
                     obstacle_x, obstacle_active);
        end
        tick(1);
        n_tests++;
        if ({obstacle_active, obstacle_height, obstacle_x, score}
            !== {1'b0, 10'd0, 10'd640, 16'd1}) begin
            n_fail++;
            $display("FAIL despawn: act=%b h=%0d x=%0d score=%0d want 0 0 640 1",
                     obstacle_active, obstacle_height, obstacle_x, score);
        end
    endtask

    task automatic test_collision();
        wait_spawn("coll");
        tick(60);
        n_tests++;
        if (obstacle_x !== 10'd400) begin
            n_fail++;
            $display("FAIL coll_pre_x: x=%0d want 400", obstacle_x);
        end
        cycle(1, 0, 1);
        n_tests++;
        if (obstacle_x !== 10'd400 || game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_freeze: x=%0d go=%b want 400 1",
                     obstacle_x, game_over);
        end
        tick(10);
        n_tests++;
        if (obstacle_x !== 10'd400 || score !== 16'd1
            || obstacle_height !== 10'(m_h)) begin
            n_fail++;
            $display("FAIL coll_hold: x=%0d score=%0d h=%0d want 400 1 %0d",
                     obstacle_x, score, obstacle_height, m_h);
        end
        cycle(0, 1, 0);
        n_tests++;
        if ({game_over, score, obstacle_active, obstacle_x}
            !== {1'b0, 16'd0, 1'b0, 10'd640}) begin
            n_fail++;
            $display("FAIL restart: go=%b score=%0d act=%b x=%0d want 0 0 0 640",
                     game_over, score, obstacle_active, obstacle_x);
        end
    endtask

    task automatic test_collision_ignored();
        do_reset(1);
        cycle(0, 0, 1);
        n_tests++;
        if (game_over !== 1'b0 || obstacle_x !== 10'd640) begin
            n_fail++;
            $display("FAIL coll_idle: go=%b x=%0d want 0 640",
                     game_over, obstacle_x);
        end
        cycle(0, 1, 0);
        tick(3);
        cycle(1, 0, 1);
        cycle(0, 1, 1);
        n_tests++;
        if (game_over !== 1'b0 || obstacle_active !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_wait: go=%b act=%b want 0 0",
                     game_over, obstacle_active);
        end
        for (int i = 0; i < 200 && m_act == 0; i++) tick(1);
        n_tests++;
        if (obstacle_active !== 1'b1 || obstacle_height !== 10'(m_h)) begin
            n_fail++;
            $display("FAIL wait_spawn_time: act=%b h=%0d want 1 %0d",
                     obstacle_active, obstacle_height, m_h);
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset(1);
        cycle(0, 1, 0);
        repeat (3) begin
            wait_spawn("mid");
            wait_despawn("mid");
        end
        wait_spawn("mid");
        tick(5);
        n_tests++;
        if (score !== 16'd3 || obstacle_active !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: score=%0d act=%b want 3 1",
                     score, obstacle_active);
        end
        do_reset(1);
        n_tests++;
        if ({obstacle_x, obstacle_y, obstacle_height, obstacle_active,
             game_over, score}
            !== {10'd640, 10'd345, 10'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: x=%0d y=%0d h=%0d act=%b go=%b score=%0d",
                     obstacle_x, obstacle_y, obstacle_height,
                     obstacle_active, game_over, score);
        end
        n_tests++;
        if (dut.u_lfsr.value !== 8'hA5) begin
            n_fail++;
            $display("FAIL mid_lfsr: lfsr=%h want a5", dut.u_lfsr.value);
        end
    endtask

    task automatic test_saturate();
        cycle(0, 1, 0);
        wait_spawn("sat");
        @(negedge clk);
        dut.score_q = 16'hFFFF;
        m_score = 65535;
        cycle(0, 0, 0);
        wait_despawn("sat");
        n_tests++;
        if (score !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate: score=%h want ffff", score);
        end
    endtask

    task automatic test_random();
        logic [9:0] my;
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(1, 0) == 1),
                  ($urandom_range(31, 0) == 0),
                  ($urandom_range(63, 0) == 0));
            my = 10'(345 - m_h);
            n_tests++;
            if ({obstacle_x, obstacle_y, obstacle_height, obstacle_active,
                 game_over, score}
                !== {10'(m_x), my, 10'(m_h), m_act, m_go, 16'(m_score)}) begin
                n_fail++;
                $display("FAIL random_%0d: x=%0d y=%0d h=%0d a=%b g=%b s=%0d want %0d %0d %0d %b %b %0d",
                         i, obstacle_x, obstacle_y, obstacle_height,
                         obstacle_active, game_over, score,
                         m_x, my, m_h, m_act, m_go, m_score);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_move_despawn();
        test_collision();
        test_collision_ignored();
        test_reset_mid_move();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
